// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting in the M stage.
// Load hits complete in the same cycle; misses and all stores stall until the backing memory acks.
module data_cache #(
  parameter int SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM_i,
  input  logic        MemWriteM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  output logic [31:0] ReadDataM_o,
  output logic        StallM_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  if (SETS < 2 || SETS > 256 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("data_cache: SETS must be a power of two in 2..256");
  end

  typedef enum logic [1:0] {IDLE, RMISS, WTHRU} state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TW-1:0]     tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic              hit;
  logic              is_store;
  logic              is_load;
  logic              line_we;
  logic [31:0]       line_wdata;
  logic              unused_addr_bits;

  assign idx      = ALUResultM_i[2+IW-1:2];
  assign tag      = ALUResultM_i[31:2+IW];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  // Both strobes high is a store.
  assign is_store = MemWriteM_i;
  assign is_load  = MemReadM_i && !MemWriteM_i;

  assign unused_addr_bits = ^ALUResultM_i[1:0];

  // Memory-side controls depend only on the registered state.
  assign mem_req_o   = (state_q == RMISS) || (state_q == WTHRU);
  assign mem_we_o    = (state_q == WTHRU);
  assign mem_addr_o  = {ALUResultM_i[31:2], 2'b00};
  assign mem_wdata_o = WriteDataM_i;

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    line_wdata   = WriteDataM_i;
    ReadDataM_o  = 32'd0;
    StallM_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_store) begin
          StallM_o = 1'b1;
          state_d  = WTHRU;
        end else if (is_load) begin
          if (hit) begin
            ReadDataM_o = data_q[idx];
            hit_count_d = sat_inc(hit_count_q);
          end else begin
            StallM_o = 1'b1;
            state_d  = RMISS;
          end
        end
      end
      RMISS: begin
        if (mem_ack_i) begin
          ReadDataM_o  = mem_rdata_i;
          line_we      = 1'b1;
          line_wdata   = mem_rdata_i;
          valid_d[idx] = 1'b1;
          miss_count_d = sat_inc(miss_count_q);
          state_d      = IDLE;
        end else begin
          StallM_o = 1'b1;
        end
      end
      WTHRU: begin
        if (mem_ack_i) begin
          // No write-allocate: only a resident line picks up the store data.
          line_we = hit;
          state_d = IDLE;
        end else begin
          StallM_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (line_we && !rst) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized transaction bench for data_cache with a line-table reference model and
// a per-cycle compare process, plus directed scenarios pinned by literal values.
module tb_data_cache;

  localparam int SETS = 16;
  localparam int IW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM_i, MemWriteM_i;
  logic [31:0] ALUResultM_i, WriteDataM_i;
  logic [31:0] ReadDataM_o;
  logic        StallM_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [31:0] hit_count_o, miss_count_o;

  always #5 clk = ~clk;

  data_cache #(.SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
    .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
    .ReadDataM_o(ReadDataM_o), .StallM_o(StallM_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, required %08h", name, act, exp);
  endtask

  // Reference model: one entry per line, addressed by plain arithmetic on the word address.
  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] m_hits, m_misses;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (2 + IW);
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_hits   = 32'd0;
    m_misses = 32'd0;
  endtask

  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, StallM_o}, {31'd0, exp_stall});
      check("rdata", ReadDataM_o, exp_rdata);
      check("mem_req", {31'd0, mem_req_o}, {31'd0, exp_req});
      if (exp_req) begin
        check("mem_we", {31'd0, mem_we_o}, {31'd0, exp_we});
        check("mem_addr", mem_addr_o, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata_o, exp_wdata);
      end
      check("hit_count", hit_count_o, m_hits);
      check("miss_count", miss_count_o, m_misses);
    end
  end

  int          obs_stalls;
  logic        obs_req;
  logic [31:0] obs_rdata;

  task automatic set_exp(input logic st, input logic [31:0] rd, input logic rq,
                         input logic we, input logic [31:0] ad, input logic [31:0] wd);
    exp_stall = st; exp_rdata = rd; exp_req = rq;
    exp_we = we; exp_addr = ad; exp_wdata = wd;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (StallM_o) obs_stalls++;
    if (mem_req_o) obs_req = 1'b1;
    obs_rdata = ReadDataM_o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    chk_en = 1'b0;
    rst = 1'b1;
    MemReadM_i = 1'b0; MemWriteM_i = 1'b0; mem_ack_i = 1'b0;
    repeat (n) cyc();
    rst = 1'b0;
    model_clear();
    chk_en = 1'b1;
  endtask

  // op: 0 idle, 1 load, 2 store, 3 load+store strobes together. lat = stalled cycles on a miss/store.
  task automatic do_txn(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata);
    int          i;
    bit          hit;
    logic [31:0] al;
    obs_stalls = 0;
    obs_req    = 1'b0;
    al  = addr & 32'hFFFF_FFFC;
    i   = idx_of(addr);
    hit = m_valid[i] && (m_tag[i] == tag_of(addr));
    ALUResultM_i = addr;
    WriteDataM_i = wdata;
    mem_ack_i    = 1'b0;
    mem_rdata_i  = $urandom;
    if (op == 0) begin
      MemReadM_i = 1'b0; MemWriteM_i = 1'b0;
      mem_ack_i  = 1'($urandom_range(0, 1));
      set_exp(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      cyc();
    end else if (op == 1) begin
      MemReadM_i = 1'b1; MemWriteM_i = 1'b0;
      if (hit) begin
        set_exp(1'b0, m_data[i], 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        m_hits = sat(m_hits);
      end else begin
        set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        for (int k = 1; k <= lat; k++) begin
          mem_ack_i   = (k == lat);
          mem_rdata_i = (k == lat) ? rdata : $urandom;
          set_exp(k != lat, (k == lat) ? rdata : 32'd0, 1'b1, 1'b0, al, wdata);
          cyc();
        end
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(addr);
        m_data[i]  = rdata;
        m_misses   = sat(m_misses);
      end
    end else begin
      MemReadM_i = (op == 3); MemWriteM_i = 1'b1;
      set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      cyc();
      for (int k = 1; k <= lat; k++) begin
        mem_ack_i   = (k == lat);
        mem_rdata_i = $urandom;
        set_exp(k != lat, 32'd0, 1'b1, 1'b1, al, wdata);
        cyc();
      end
      if (hit) m_data[i] = wdata;
    end
    MemReadM_i = 1'b0; MemWriteM_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  logic [31:0] tags [4];

  initial begin
    rst = 1'b1;
    MemReadM_i = 1'b0; MemWriteM_i = 1'b0;
    ALUResultM_i = 32'd0; WriteDataM_i = 32'd0;
    mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
    model_clear();
    do_reset(2);

    // Reset state, idle cycle with a stray ack.
    do_txn(0, 32'h0000_0040, 32'd0, 1, 32'd0);
    check("reset_hits", hit_count_o, 32'd0);
    check("reset_misses", miss_count_o, 32'd0);

    // Cold load miss, ack after three stalled cycles.
    do_txn(1, 32'h0000_0100, 32'd0, 3, 32'hDEAD_BEEF);
    check("miss_stalls", obs_stalls, 3);
    check("miss_rdata", obs_rdata, 32'hDEAD_BEEF);
    check("miss_count1", miss_count_o, 32'd1);

    // Repeat load hits with no stall and no memory request.
    do_txn(1, 32'h0000_0100, 32'd0, 1, 32'd0);
    check("hit_stalls", obs_stalls, 0);
    check("hit_rdata", obs_rdata, 32'hDEAD_BEEF);
    check("hit_req", {31'd0, obs_req}, 32'd0);
    check("hit_count1", hit_count_o, 32'd1);

    // Store hit updates the line; following load sees the new data.
    do_txn(2, 32'h0000_0100, 32'h1234_5678, 2, 32'd0);
    check("store_stalls", obs_stalls, 2);
    check("store_counts", hit_count_o + miss_count_o, 32'd2);
    do_txn(1, 32'h0000_0100, 32'd0, 1, 32'd0);
    check("store_hit_rdata", obs_rdata, 32'h1234_5678);
    check("hit_count2", hit_count_o, 32'd2);

    // Conflict on index 0: 0x140 evicts 0x100.
    do_txn(1, 32'h0000_0140, 32'd0, 1, 32'hAAAA_0140);
    check("conflict_a", obs_stalls, 1);
    do_txn(1, 32'h0000_0100, 32'd0, 2, 32'hBBBB_0100);
    check("conflict_b", obs_stalls, 2);
    check("miss_count3", miss_count_o, 32'd3);

    // Store to an uncached address does not allocate.
    do_txn(2, 32'h0000_0200, 32'h5555_0200, 1, 32'd0);
    do_txn(1, 32'h0000_0200, 32'd0, 1, 32'h6666_0200);
    check("no_alloc_miss", obs_stalls, 1);

    // Both strobes high behave as a store.
    do_txn(3, 32'h0000_0200, 32'h7777_0200, 1, 32'd0);
    do_txn(1, 32'h0000_0203, 32'd0, 1, 32'd0);
    check("both_as_store", obs_rdata, 32'h7777_0200);

    // Reset in the middle of a read miss; a late ack must be ignored.
    do_reset(1);
    ALUResultM_i = 32'h0000_0100; MemReadM_i = 1'b1; mem_ack_i = 1'b0;
    set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    set_exp(1'b1, 32'd0, 1'b1, 1'b0, 32'h0000_0100, WriteDataM_i);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    MemReadM_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    set_exp(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    mem_ack_i = 1'b0;
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_counts", hit_count_o | miss_count_o, 32'd0);
    do_txn(1, 32'h0000_0100, 32'd0, 2, 32'h0BAD_F00D);
    check("rst_then_miss", obs_stalls, 2);
    check("rst_miss_count", miss_count_o, 32'd1);

    // Random traffic over a small address pool so lines are reused and evicted.
    tags[0] = 32'd0; tags[1] = 32'd5; tags[2] = 32'h3FF_FFFF; tags[3] = 32'd1;
    for (int n = 0; n < 400; n++) begin
      int          r;
      int          op;
      logic [31:0] a;
      r  = $urandom_range(0, 7);
      op = (r == 0) ? 0 : (r <= 4) ? 1 : (r <= 6) ? 2 : 3;
      a  = (tags[$urandom_range(0, 3)] << (2 + IW)) | (32'($urandom_range(0, SETS - 1)) << 2)
           | 32'($urandom_range(0, 3));
      do_txn(op, a, $urandom, $urandom_range(1, 4), $urandom);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped lines; SHALL be a power of two, 2..256.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 MemReadM_i  in  1  M-stage load request; held stable by the pipeline while StallM_o=1.
REQ-005 MemWriteM_i  in  1  M-stage store request; held stable while StallM_o=1.
REQ-006 ALUResultM_i  in  32  byte address; bits [1:0] ignored (word access only).
REQ-007 WriteDataM_i  in  32  store data.
REQ-008 ReadDataM_o  out  32  load data to the MW pipeline register.
REQ-009 StallM_o  out  1  freezes PC, FD, DE, EM and MW registers while high.
REQ-010 mem_req_o / mem_we_o  out  1 / 1  backing-memory request and write enable.
REQ-011 mem_addr_o / mem_wdata_o  out  32 / 32  word-aligned address and store data.
REQ-012 mem_rdata_i / mem_ack_i  in  32 / 1  read data and one-cycle completion strobe.
REQ-013 hit_count_o / miss_count_o  out  32 / 32  load hit and load miss counters.

Function
REQ-014 Storage SHALL be SETS lines of {valid, tag, 32-bit data}: index = addr[2+log2(SETS)-1:2], tag = addr[31:2+log2(SETS)].
REQ-015 FSM states SHALL be IDLE, RMISS and WTHRU.
REQ-016 Hit SHALL be defined as valid[index] && tag[index]==tag(addr).
REQ-017 IDLE, load hit: ReadDataM_o = line data combinationally, StallM_o=0, no memory request, hit_count_o += 1 at the clock edge.
REQ-018 IDLE, load miss: StallM_o=1 in the same cycle; next state RMISS.
REQ-019 RMISS: mem_req_o=1, mem_we_o=0, mem_addr_o={addr[31:2],2'b00}, StallM_o=1 until mem_ack_i.
REQ-020 RMISS with mem_ack_i=1: ReadDataM_o=mem_rdata_i and StallM_o=0 in that cycle; at the edge, write line {1, tag, mem_rdata_i}, miss_count_o += 1, next state IDLE.
REQ-021 IDLE, store (hit or miss): StallM_o=1; next state WTHRU (write-through, no write-allocate).
REQ-022 WTHRU: mem_req_o=1, mem_we_o=1, mem_addr_o aligned, mem_wdata_o=WriteDataM_i, StallM_o=1 until mem_ack_i.
REQ-023 WTHRU with mem_ack_i=1: StallM_o=0; at the edge update line data only if hit; a miss leaves the line unchanged; next state IDLE.
REQ-024 MemReadM_i and MemWriteM_i both high SHALL be treated as a store.
REQ-025 mem_ack_i in IDLE SHALL be ignored; outside RMISS/WTHRU, mem_req_o SHALL be 0.
REQ-026 Counters SHALL saturate at 32'hFFFF_FFFF; stores SHALL NOT change either counter.
REQ-027 A load to the same address after its fill SHALL hit on the next IDLE cycle; there is no extra latency.
REQ-028 With no request, ReadDataM_o SHALL be 0 and StallM_o SHALL be 0.

Reset
REQ-029 rst SHALL clear all valid bits and both counters, force IDLE and deassert mem_req_o on the next edge, including mid-RMISS/WTHRU; any in-flight ack SHALL be discarded.
REQ-030 Tag and data arrays need no reset.

Verification
REQ-031 After rst, load 0x100 with mem_rdata_i=0xDEADBEEF and ack after 3 cycles -> StallM_o high for 3 cycles, ReadDataM_o=0xDEADBEEF on the ack cycle, miss_count_o=1.
REQ-032 Repeat load 0x100 -> StallM_o=0, ReadDataM_o=0xDEADBEEF the same cycle, no mem_req_o, hit_count_o=1.
REQ-033 Store 0x12345678 to 0x100, ack after 2 cycles -> mem_we_o=1, mem_wdata_o=0x12345678; a following load of 0x100 hits with 0x12345678.
REQ-034 Conflict test (SETS=16): load 0x100 then 0x140 (same index) -> both miss; a third load of 0x100 misses again; miss_count_o=3.
REQ-035 Store to uncached 0x200, then load 0x200 -> the load misses (no allocate).
REQ-036 Assert rst during RMISS before ack -> mem_req_o=0 next cycle; a late ack is ignored; load 0x100 afterwards misses; counters are 0.
